// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg: shared SPI mode-0 constants and master state encoding. Rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETUP = 3'd1;
  localparam logic [STATE_W-1:0] ST_HIGH  = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOW   = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_clk_div: one-cycle tick every CLK_DIV cycles while enabled. Rev 1.0
// ---------------------------------------------------------------------------
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Held at zero while disabled so every phase starts with a full count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master: single-transfer SPI mode-0 master, MSB first. Rev 1.0
// ---------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ss
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [STATE_W-1:0]    state;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [BW-1:0]         bit_cnt;
  logic                  tick;
  logic                  div_en;

  assign div_en = (state != ST_IDLE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .tick (tick)
  );

  // mosi is the shift-register MSB, so it only moves when tx_sr is loaded,
  // shifted on a falling sclk, or cleared as ss deasserts.
  assign mosi = tx_sr[DATA_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ss      <= 1'b1;
      sclk    <= CPOL;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sr   <= tx_data;
            ss      <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sclk  <= ~CPOL;
            state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sclk  <= CPOL;
            rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
            if (bit_cnt == LAST_BIT) begin
              state <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_sr   <= tx_sr << 1;
              state   <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (tick) begin
            sclk  <= ~CPOL;
            state <= ST_HIGH;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            ss      <= 1'b1;
            busy    <= 1'b0;
            tx_sr   <= '0;
            rx_data <= rx_sr;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_spi_master: scoreboard bench for spi_master with a behavioural slave.
// ---------------------------------------------------------------------------
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default parameters
  logic       rst, start, busy, done, sclk, mosi, miso, ss;
  logic [7:0] tx_data, rx_data;

  // Back-to-back instance, CLK_DIV=1
  logic       rst1, start1, busy1, done1, sclk1, mosi1, miso1, ss1;
  logic [7:0] tx_data1, rx_data1;

  spi_master dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy),
    .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
  );

  spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .tx_data(tx_data1), .busy(busy1),
    .done(done1), .rx_data(rx_data1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .ss(ss1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural mode-0 slave: presents MSB on ss fall, shifts out on sclk fall.
  logic       miso_sel;
  logic [7:0] slave_tx, sl_sr, sl_rx;
  assign miso = (miso_sel && !ss) ? sl_sr[7] : 1'b0;
  always @(negedge ss) sl_sr = slave_tx;
  always @(posedge sclk) if (!ss) sl_rx = {sl_rx[6:0], mosi};
  always @(negedge sclk) if (!ss) sl_sr = {sl_sr[6:0], 1'b0};

  typedef struct packed {
    logic [7:0] rx;
    logic [7:0] mo;
  } exp_t;
  exp_t q[$];
  exp_t e;

  // Monitor state
  logic [7:0] acc, acc1;
  int   len, rises, len1, gap1, n1;
  bit   in_win, in1, seen1;
  logic psclk, psclk1;

  initial begin
    n1 = 0; in_win = 0; in1 = 0; seen1 = 0; gap1 = 0; psclk = 0; psclk1 = 0;
    len = 0; rises = 0; len1 = 0; acc = 0; acc1 = 0; sl_rx = 0; sl_sr = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      in_win = 0;
      psclk  = 0;
    end else begin
      if (!ss) begin
        if (!in_win) begin
          in_win = 1; len = 0; rises = 0; acc = 0;
        end
        len++;
        if (sclk && !psclk) begin
          acc = {acc[6:0], mosi};
          rises++;
        end
      end else begin
        in_win = 0;
      end
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("rx_data", rx_data, e.rx);
          check("mosi_bits", acc, e.mo);
          check("ss_low_cycles", len, 68);
          check("sclk_rises", rises, 8);
          check("ss_at_done", ss, 1);
          check("busy_at_done", busy, 0);
        end
      end
      psclk = sclk;
    end

    if (rst1) begin
      in1 = 0; seen1 = 0; gap1 = 0; psclk1 = 0;
    end else if (n1 < 4) begin
      if (!ss1) begin
        if (!in1) begin
          in1 = 1;
          if (seen1) check("b2b_gap", gap1, 1);
          len1 = 0; acc1 = 0;
        end
        len1++;
        if (sclk1 && !psclk1) acc1 = {acc1[6:0], mosi1};
      end else begin
        if (in1) begin
          in1 = 0; seen1 = 1; gap1 = 0;
        end
        gap1++;
      end
      if (done1) begin
        n1++;
        check("b2b_rx", rx_data1, 8'h00);
        check("b2b_mosi", acc1, 8'h96);
        check("b2b_ss_low", len1, 17);
      end
      psclk1 = sclk1;
    end
  end

  task automatic launch(input logic [7:0] tx);
    @(negedge clk);
    check("busy_idle", busy, 0);
    start   = 1'b1;
    tx_data = tx;
    @(negedge clk);
    start   = 1'b0;
    tx_data = ~tx;
    check("busy_rise", busy, 1);
    check("ss_fall", ss, 0);
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check(name, got, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    start = 1'b0; start1 = 1'b0;
    tx_data = 8'h00; tx_data1 = 8'h96; miso1 = 1'b0;
    miso_sel = 1'b0; slave_tx = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ss", ss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 0);
    rst = 1'b0; rst1 = 1'b0;
    start1 = 1'b1;

    // 0x0D out, miso tied low
    miso_sel = 1'b0;
    q.push_back('{rx: 8'h00, mo: 8'h0D});
    launch(8'h0D);
    wait_done("done_0d");

    // 0xA5 in from the slave model, 0x3C out
    miso_sel = 1'b1; slave_tx = 8'hA5;
    q.push_back('{rx: 8'hA5, mo: 8'h3C});
    launch(8'h3C);
    wait_done("done_a5");
    check("slave_rx_3c", sl_rx, 8'h3C);

    // Slave loaded with 13, master sends 0x0A
    slave_tx = 8'd13;
    q.push_back('{rx: 8'h0D, mo: 8'h0A});
    launch(8'h0A);
    wait_done("done_slave");
    check("slave_rx_0a", sl_rx, 8'h0A);

    // Reset 20 cycles into a transfer
    slave_tx = 8'hFF;
    launch(8'hFF);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ss", ss, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_mosi", mosi, 0);
    check("abort_rx", rx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_done_rx", rx_data, 0);

    // start during a transfer is ignored
    miso_sel = 1'b0;
    q.push_back('{rx: 8'h00, mo: 8'h5A});
    launch(8'h5A);
    repeat (8) @(negedge clk);
    start = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done("done_5a");
    repeat (80) @(negedge clk);
    check("no_second_xfer", busy, 0);

    check("queue_empty", q.size(), 0);
    check("b2b_windows", n1, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Single-byte SPI mode-0 master that generates `sclk`, `ss` and `mosi` from the system clock and captures `miso`. It sits directly upstream of `spi_slave`, driving that block's `sclk`/`mosi`/`ss` pins and consuming its `miso`. The host side is a start/busy/done handshake with parallel `tx_data` in and `rx_data` out. Transfers are MSB first.

## Interface
- `CLK_DIV`, default 4: system clocks per `sclk` half-period; legal range is 1 or greater.
- `DATA_WIDTH`, default 8: bits per transfer.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: transfer request; sampled only when idle.
- `tx_data`  in  DATA_WIDTH: byte to send; latched on the accepting edge.
- `busy`  out  1: high while a transfer is in progress.
- `done`  out  1: one-cycle pulse when `rx_data` becomes valid.
- `rx_data`  out  DATA_WIDTH: last received byte; holds its value until the next `done`.
- `sclk`  out  1: SPI clock; idles low (CPOL=0).
- `mosi`  out  1: serial data out.
- `miso`  in  1: serial data in.
- `ss`  out  1: slave select, active-low.

## Operation
- Reset values: `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, state=IDLE, counters=0.
- Reset asserted mid-transfer aborts it immediately with the reset values above. No `done` pulse is produced and `rx_data` is cleared.
- States and transitions:
  - IDLE: on `start`=1, latch `tx_data` into the shift register, drive `ss`=0, drive `mosi`=`tx_data[DATA_WIDTH-1]`, set `busy`=1, then go to SETUP.
  - SETUP: hold `sclk`=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: hold `sclk`=1 for CLK_DIV cycles.
    - On the edge that ends HIGH, shift `miso` into the receive register LSB and drive `sclk`=0.
    - If bits remain, shift the next bit onto `mosi` and go to LOW.
    - Otherwise go to HOLD.
  - LOW: hold `sclk`=0 for CLK_DIV cycles, then go to HIGH.
  - HOLD: hold `sclk`=0 for CLK_DIV cycles. On exit: `ss`=1, `busy`=0, copy the receive register to `rx_data`, assert `done` for one cycle, go to IDLE.
- `start` while `busy`=1 is ignored, with no queuing. `tx_data` changes after the accepting edge have no effect on the transfer.
- `mosi` changes only on `sclk` falling edges or on `ss` assertion. This guarantees CLK_DIV cycles of setup before every rising edge.
- Bit counter counts DATA_WIDTH rising edges, from 0 to DATA_WIDTH-1; it does not wrap within a transfer.
- `mosi` returns to 0 when `ss` deasserts.

## Timing
- `ss` is low for exactly (2·DATA_WIDTH+1)·CLK_DIV cycles. With defaults this is 68 cycles.
- The first `sclk` rise occurs CLK_DIV cycles after `ss` falls.
- `busy` rises on the cycle after the start edge. `done` pulses the same cycle that `ss` rises and `busy` falls.
- `done` cycle equals the first IDLE cycle. `start` asserted in that cycle is accepted, so back-to-back transfers see `ss` high for exactly 1 cycle.
- `sclk` duty cycle is 50%; its period is 2·CLK_DIV system clocks.
- With CLK_DIV=1, every phase lasts one cycle and the behaviour must be otherwise identical.

## Structure
- Shared package `spi_pkg` contains:
  - the state encoding (IDLE, SETUP, HIGH, LOW, HOLD);
  - the default DATA_WIDTH;
  - the mode-0 constants CPOL=0 and CPHA=0, also used by `spi_slave`.
- Sub-module `spi_clk_div` is a half-period counter that emits a one-cycle `tick` every CLK_DIV cycles while enabled. It restarts at 0 when enabled and clears asynchronously on `rst`.

## Test plan
- Send `tx_data`=0x0D with `miso` tied to 0, with the defaults:
  - `mosi` sampled at the 8 `sclk` rising edges reads 0,0,0,0,1,1,0,1;
  - `rx_data`=0x00 and one `done` pulse;
  - `ss` low for 68 cycles.
- Drive the `miso` sequence for 0xA5 with `tx_data`=0x3C, with the stimulus changing on `sclk` falling edges: `rx_data`=0xA5 at `done`, and `mosi` carries 0x3C.
- Connect `spi_slave` as the load, loading its `tx_data` with 13 and sending 0x0A: the slave's `rx_data`=0x0A, and the master's `rx_data`=0x0D.
- Pulse `start` again 10 cycles into a transfer with a different `tx_data`: there is no effect, and one `done` with the original data.
- Assert `rst` 20 cycles into a transfer: within the same cycle `ss`=1, `sclk`=0, `busy`=0. No `done` pulse, and `rx_data`=0.
- Run with CLK_DIV=1 and hold `start` high continuously: transfers run back-to-back, each `ss`-low window is 17 cycles, and there is a 1-cycle `ss`-high gap between windows.
